// File: rtl/atm_cash_dispenser.sv
// atm_cash_dispenser
// Cash-dispenser responder for the ATM withdraw path. A request is converted to
// a note count by repeated subtraction. The feed motor is then pulsed once per
// note, and each note must be confirmed on the exit sensor. The block reports
// completion with a single done pulse and a status code. It also keeps the
// cassette inventory, accepts refills while idle, and latches a jam fault.
//
// Optional build macro: ATM_DISP_RETRY_EN
//   defined   : the first sensor timeout in a transaction re-feeds the note once;
//               a second timeout raises the jam fault
//   undefined : the first sensor timeout raises the jam fault
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ready for a request or a refill
// CALC       | one note subtraction per cycle, then amount/inventory checks
// FEED       | feed_motor pulse is out; sensor timer is loaded
// WAIT_SENSE | waiting for note_sense; timer counts down to its terminal count
// DONE       | done pulse with OK / BAD_AMOUNT / INSUFFICIENT
// FAULT      | done pulse with JAM; jam is latched

module atm_cash_dispenser #(
    parameter int AMT_W      = 32,
    parameter int NOTE_W     = 16,
    parameter int NOTE_VALUE = 100,
    parameter int INIT_NOTES = 50,
    parameter int MAX_NOTES  = 40,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [AMT_W-1:0]  req_amount,
    output logic              req_ready,
    input  logic              note_sense,
    output logic              feed_motor,
    input  logic              refill_valid,
    input  logic [NOTE_W-1:0] refill_notes,
    input  logic              clear_jam,
    output logic              done,
    output logic [1:0]        status,
    output logic [AMT_W-1:0]  disp_amount,
    output logic [NOTE_W-1:0] notes_left,
    output logic              jam
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [AMT_W-1:0]  NOTE_AMT  = AMT_W'(NOTE_VALUE);
    localparam logic [NOTE_W-1:0] MAX_CNT   = NOTE_W'(MAX_NOTES);
    localparam logic [NOTE_W-1:0] INIT_CNT  = NOTE_W'(INIT_NOTES);
    localparam logic [NOTE_W-1:0] ONE_NOTE  = NOTE_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_BAD   = 2'b01;
    localparam logic [1:0] ST_INSUF = 2'b10;
    localparam logic [1:0] ST_JAM   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FEED,
        WAIT_SENSE,
        DONE,
        FAULT
    } state_t;

    state_t            state;
    logic [AMT_W-1:0]  rem;
    logic [AMT_W-1:0]  disp_acc;
    logic [NOTE_W-1:0] cnt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic [NOTE_W:0]   refill_sum;
`ifdef ATM_DISP_RETRY_EN
    logic              retried;
`endif

    // Refill is only honoured in IDLE, so it also blocks a simultaneous request.
    assign req_ready  = (state == IDLE) & ~jam & ~refill_valid;
    assign refill_sum = {1'b0, notes_left} + {1'b0, refill_notes};
    assign timer_next = timer - 1'b1;

    // Main controller: sequencing, inventory, status and the registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rem         <= '0;
            disp_acc    <= '0;
            cnt         <= '0;
            timer       <= '0;
            feed_motor  <= 1'b0;
            done        <= 1'b0;
            status      <= ST_OK;
            disp_amount <= '0;
            notes_left  <= INIT_CNT;
            jam         <= 1'b0;
`ifdef ATM_DISP_RETRY_EN
            retried     <= 1'b0;
`endif
        end else begin
            feed_motor <= 1'b0;
            done       <= 1'b0;

            // A jam raised in the same cycle below takes priority over this clear.
            if (clear_jam && jam) begin
                jam <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (refill_valid) begin
                        notes_left <= refill_sum[NOTE_W] ? '1 : refill_sum[NOTE_W-1:0];
                    end else if (req_valid && req_ready) begin
                        rem      <= req_amount;
                        cnt      <= '0;
                        disp_acc <= '0;
`ifdef ATM_DISP_RETRY_EN
                        retried  <= 1'b0;
`endif
                        state    <= CALC;
                    end
                end

                CALC: begin
                    if (rem >= NOTE_AMT) begin
                        // Another subtraction would push the count past the per-transaction cap.
                        if (cnt >= MAX_CNT) begin
                            status      <= ST_BAD;
                            disp_amount <= '0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem <= rem - NOTE_AMT;
                            cnt <= cnt + ONE_NOTE;
                        end
                    end else if (rem != '0 || cnt == '0) begin
                        status      <= ST_BAD;
                        disp_amount <= '0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (cnt > notes_left) begin
                        status      <= ST_INSUF;
                        disp_amount <= '0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        feed_motor <= 1'b1;
                        state      <= FEED;
                    end
                end

                FEED: begin
                    timer <= TMR_LOAD;
                    state <= WAIT_SENSE;
                end

                WAIT_SENSE: begin
                    if (note_sense) begin
                        if (notes_left != '0) begin
                            notes_left <= notes_left - ONE_NOTE;
                        end
                        disp_acc <= disp_acc + NOTE_AMT;
                        cnt      <= cnt - ONE_NOTE;
                        if (cnt == ONE_NOTE) begin
                            status      <= ST_OK;
                            disp_amount <= disp_acc + NOTE_AMT;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            feed_motor <= 1'b1;
                            state      <= FEED;
                        end
                    end else begin
                        timer <= timer_next;
                        if (timer_next == '0) begin
`ifdef ATM_DISP_RETRY_EN
                            if (!retried) begin
                                retried    <= 1'b1;
                                feed_motor <= 1'b1;
                                state      <= FEED;
                            end else begin
                                jam         <= 1'b1;
                                status      <= ST_JAM;
                                disp_amount <= disp_acc;
                                done        <= 1'b1;
                                state       <= FAULT;
                            end
`else
                            jam         <= 1'b1;
                            status      <= ST_JAM;
                            disp_amount <= disp_acc;
                            done        <= 1'b1;
                            state       <= FAULT;
`endif
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                FAULT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed bench for atm_cash_dispenser: a table of withdrawals followed by
// hand-written refill, jam, refill-vs-request and mid-transaction reset sequences.
module tb_atm_cash_dispenser;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_amount;
    logic        req_ready;
    logic        note_sense;
    logic        feed_motor;
    logic        refill_valid;
    logic [15:0] refill_notes;
    logic        clear_jam;
    logic        done;
    logic [1:0]  status;
    logic [31:0] disp_amount;
    logic [15:0] notes_left;
    logic        jam;

    int errors = 0;
    int checks = 0;

    atm_cash_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .note_sense   (note_sense),
        .feed_motor   (feed_motor),
        .refill_valid (refill_valid),
        .refill_notes (refill_notes),
        .clear_jam    (clear_jam),
        .done         (done),
        .status       (status),
        .disp_amount  (disp_amount),
        .notes_left   (notes_left),
        .jam          (jam)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] amt;
        int          sense_n;
        logic [1:0]  exp_status;
        logic [31:0] exp_disp;
        int          exp_feeds;
        int          exp_notes;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller must be at a negedge. Drives the request, answers each feed with a
    // sensor pulse 3 cycles later (for the first sense_n feeds), waits for done.
    task automatic run_txn(input logic [31:0] amt, input int sense_n,
                           output logic [1:0] st, output logic [31:0] dsp,
                           output int feeds, output int lat, output bit got_done);
        int cd;
        cd       = -1;
        feeds    = 0;
        lat      = -1;
        got_done = 1'b0;
        st       = 2'b00;
        dsp      = '0;
        req_valid  = 1'b1;
        req_amount = amt;
        for (int k = 1; k <= 2000 && !got_done; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            note_sense = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) note_sense = 1'b1;
            end
            if (feed_motor) begin
                feeds++;
                if (lat < 0) lat = k;
                if (feeds <= sense_n) cd = 3;
            end
            if (done) begin
                got_done = 1'b1;
                st       = status;
                dsp      = disp_amount;
            end
        end
        note_sense = 1'b0;
        if (!got_done) $display("FAIL txn_timeout: amount %0d gave no done within 2000 cycles", amt);
        @(negedge clk);
        chk("done_width", done, 0);
    endtask

    task automatic do_refill(input logic [15:0] n, input int exp_notes);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_notes = n;
        @(negedge clk);
        refill_valid = 1'b0;
        chk("refill_notes_left", notes_left, exp_notes);
    endtask

    initial begin
        logic [1:0]  st;
        logic [31:0] dsp;
        int          feeds;
        int          lat;
        bit          got;
        int          cd;
        int          dones_after;
        int          feeds_after;
        int          exp_jam_feeds;

`ifdef ATM_DISP_RETRY_EN
        exp_jam_feeds = 4;
`else
        exp_jam_feeds = 3;
`endif

        //            amt   sense st     disp  feeds notes lat
        vecs[0] = '{  300,  99, 2'b00,  300,   3,   47,   5};
        vecs[1] = '{  250,  99, 2'b01,    0,   0,   47,   0};
        vecs[2] = '{    0,  99, 2'b01,    0,   0,   47,   0};
        vecs[3] = '{ 4500,  99, 2'b01,    0,   0,   47,   0};
        vecs[4] = '{ 4100,  99, 2'b01,    0,   0,   47,   0};
        vecs[5] = '{   99,  99, 2'b01,    0,   0,   47,   0};
        vecs[6] = '{ 4000,  99, 2'b00, 4000,  40,    7,  42};
        vecs[7] = '{  800,  99, 2'b10,    0,   0,    7,   0};
        vecs[8] = '{  700,  99, 2'b00,  700,   7,    0,   9};
        vecs[9] = '{  100,  99, 2'b10,    0,   0,    0,   0};

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_amount   = '0;
        note_sense   = 1'b0;
        refill_valid = 1'b0;
        refill_notes = '0;
        clear_jam    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_feed", feed_motor, 0);
        chk("rst_done", done, 0);
        chk("rst_jam", jam, 0);
        chk("rst_status", status, 0);
        chk("rst_disp", disp_amount, 0);
        chk("rst_notes", notes_left, 50);
        chk("rst_ready", req_ready, 1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run_txn(vecs[i].amt, vecs[i].sense_n, st, dsp, feeds, lat, got);
            chk($sformatf("v%0d_done", i), got, 1);
            chk($sformatf("v%0d_status", i), st, vecs[i].exp_status);
            chk($sformatf("v%0d_disp", i), dsp, vecs[i].exp_disp);
            chk($sformatf("v%0d_feeds", i), feeds, vecs[i].exp_feeds);
            chk($sformatf("v%0d_notes", i), notes_left, vecs[i].exp_notes);
            if (vecs[i].exp_feeds > 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Refill from empty, insufficient request, then saturation.
        do_refill(16'd10, 10);
        @(negedge clk);
        run_txn(32'd1500, 99, st, dsp, feeds, lat, got);
        chk("insuf_done", got, 1);
        chk("insuf_status", st, 2'b10);
        chk("insuf_disp", dsp, 0);
        chk("insuf_feeds", feeds, 0);
        do_refill(16'd65530, 65535);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_notes", notes_left, 50);

        // Sensor goes silent after two notes.
        run_txn(32'd500, 2, st, dsp, feeds, lat, got);
        chk("jam_done", got, 1);
        chk("jam_status", st, 2'b11);
        chk("jam_disp", dsp, 200);
        chk("jam_feeds", feeds, exp_jam_feeds);
        chk("jam_notes", notes_left, 48);
        chk("jam_latched", jam, 1);
        chk("jam_ready", req_ready, 0);
        @(negedge clk);
        chk("jam_held", jam, 1);
        clear_jam = 1'b1;
        @(negedge clk);
        clear_jam = 1'b0;
        chk("clear_jam", jam, 0);
        chk("clear_ready", req_ready, 1);

        // Refill and request together: refill wins, request taken next cycle.
        @(negedge clk);
        refill_valid = 1'b1;
        refill_notes = 16'd2;
        req_valid    = 1'b1;
        req_amount   = 32'd100;
        #1;
        chk("both_ready", req_ready, 0);
        @(negedge clk);
        refill_valid = 1'b0;
        chk("both_notes", notes_left, 50);
        #1;
        chk("both_still_idle", req_ready, 1);
        run_txn(32'd100, 99, st, dsp, feeds, lat, got);
        chk("both_done", got, 1);
        chk("both_status", st, 2'b00);
        chk("both_disp", dsp, 100);
        chk("both_latency", lat, 3);
        chk("both_notes_after", notes_left, 49);

        // Reset while waiting on the sensor for the second note of 400.
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 32'd400;
        cd    = -1;
        feeds = 0;
        for (int k = 1; k <= 200 && feeds < 2; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            note_sense = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) note_sense = 1'b1;
            end
            if (feed_motor) begin
                feeds++;
                if (feeds == 1) cd = 3;
            end
        end
        note_sense = 1'b0;
        chk("mid_feeds", feeds, 2);
        repeat (4) @(negedge clk);
        chk("mid_notes_before", notes_left, 48);
        reset = 1'b0;
        #1;
        chk("mid_rst_notes", notes_left, 50);
        chk("mid_rst_disp", disp_amount, 0);
        chk("mid_rst_status", status, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_feed", feed_motor, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones_after = 0;
        feeds_after = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones_after++;
            if (feed_motor) feeds_after++;
        end
        chk("mid_no_done", dones_after, 0);
        chk("mid_no_feed", feeds_after, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_notes_after", notes_left, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
